// File: rtl/data_mem_lsu.sv
// data_mem_lsu: word-organised data memory with a byte/halfword/word load-store port.
// After reset the array is cleared one word per cycle (INIT). Requests are then
// accepted every cycle (RUN), and each one is answered one cycle later.
//
// Ports
//   dmem_clk      sole clock, rising edge
//   dmem_rst      synchronous active-high reset; restarts the clear sequence
//   req_valid     request present
//   req_ready     request accepted this cycle (high only in RUN)
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned  zero-extend (1) or sign-extend (0) byte/half loads
//   req_addr      byte address: word index [ADDR_W-1:2], lane [1:0]
//   req_wdata     right-justified store data
//   rsp_valid     one-cycle response pulse, one cycle after acceptance
//   rsp_rdata     extended load data; 0 for stores and errors
//   rsp_err       misaligned or illegal request
//   init_done     memory clear complete
module data_mem_lsu #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              dmem_clk,
  input  logic              dmem_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int unsigned      IDX_W    = ADDR_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [IDX_W-1:0] clr_idx;
  logic [31:0]      mem [DEPTH];

  logic [IDX_W-1:0] word_idx;
  logic [1:0]       lane;
  logic [4:0]       lane_sh;
  logic             misaligned;
  logic             accept;
  logic             store_en;
  logic [3:0]       byte_en;
  logic [31:0]      wr_data;
  logic [31:0]      rd_word;
  logic [31:0]      rd_shift;
  logic [31:0]      load_data;

  // State register
  always_ff @(posedge dmem_clk) begin
    if (dmem_rst) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (clr_idx == LAST_IDX) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // State outputs
  always_comb begin
    req_ready = 1'b0;
    init_done = 1'b0;
    if (state_q == S_RUN) begin
      req_ready = 1'b1;
      init_done = 1'b1;
    end
  end

  // Clear index; wraps back to 0 after the last word so a later reset starts clean
  always_ff @(posedge dmem_clk) begin
    if (dmem_rst) begin
      clr_idx <= '0;
    end else if (state_q == S_INIT) begin
      clr_idx <= clr_idx + 1'b1;
    end
  end

  assign word_idx = req_addr[ADDR_W-1:2];
  assign lane     = req_addr[1:0];
  assign lane_sh  = {lane, 3'b000};

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |lane;
      default: misaligned = 1'b1;
    endcase
  end

  assign accept   = req_valid & req_ready;
  assign store_en = accept & req_we & ~misaligned;

  always_comb begin
    byte_en = '0;
    case (req_size)
      2'b00:   byte_en = 4'b0001 << lane;
      2'b01:   byte_en = 4'b0011 << lane;
      2'b10:   byte_en = '1;
      default: byte_en = '0;
    endcase
  end

  assign wr_data = req_wdata << lane_sh;

  // Aligned half lanes are 0 or 2, so the byte-lane shift also right-justifies halves
  assign rd_word  = mem[word_idx];
  assign rd_shift = rd_word >> lane_sh;

  always_comb begin
    load_data = rd_word;
    case (req_size)
      2'b00:   load_data = {{24{~req_unsigned & rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   load_data = {{16{~req_unsigned & rd_shift[15]}}, rd_shift[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Memory array: clear during INIT, byte-enabled stores during RUN
  always_ff @(posedge dmem_clk) begin
    if (!dmem_rst) begin
      if (state_q == S_INIT) begin
        mem[clr_idx] <= '0;
      end else if (store_en) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Response register; the load reads the array before this edge's write lands
  always_ff @(posedge dmem_clk) begin
    if (dmem_rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept & misaligned;
      rsp_rdata <= (accept && !req_we && !misaligned) ? load_data : '0;
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: directed cases plus randomized traffic
// against a byte-addressed reference memory.
module tb_data_mem_lsu;

  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned NBYTES = DEPTH * 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              init_done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] ref_mem [NBYTES];

  always #5 clk = ~clk;

  data_mem_lsu #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .dmem_clk     (clk),
    .dmem_rst     (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .init_done    (init_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int unsigned i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
  endtask

  // One request cycle (or idle cycle when v=0); expectations come from the byte model
  task automatic do_req(input logic v, input logic we, input logic [1:0] size,
                        input logic uns, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] wd);
    int          nb;
    int          a;
    logic        e;
    logic [31:0] d;
    nb = 1 << size;
    a  = int'(addr);
    e  = (size == 2'b11) || (a % nb != 0);
    d  = '0;
    if (v && !e) begin
      if (we) begin
        for (int i = 0; i < nb; i++) ref_mem[a+i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) d[8*i +: 8] = ref_mem[a+i];
        if (!uns && nb < 4 && d[8*nb-1]) d = d | (32'hFFFF_FFFF << (8*nb));
      end
    end
    req_valid    = v;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rsp_valid", 32'(rsp_valid), 32'(v));
    if (v) begin
      chk("rsp_err", 32'(rsp_err), 32'(e));
      chk("rsp_rdata", rsp_rdata, d);
    end
  endtask

  // Counts edges until init_done, bounded; also counts any stray responses meanwhile
  task automatic wait_init(output int cycles, output int stray);
    cycles = 0;
    stray  = 0;
    while (cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
      if (rsp_valid) stray++;
      if (init_done) break;
    end
  endtask

  initial begin
    int                cyc;
    int                stray;
    logic              v;
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] mask;

    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'd0);

    // Requests presented during INIT must be ignored
    rst       = 1'b0;
    req_valid = 1'b1;
    req_addr  = 7'h00;
    req_size  = 2'b10;
    wait_init(cyc, stray);
    req_valid = 1'b0;
    chk("init_cycles", 32'(cyc), 32'd32);
    chk("init_stray_rsp", 32'(stray), 32'd0);
    chk("run_req_ready", 32'(req_ready), 32'd1);
    model_clear();

    do_req(1'b1, 1'b0, 2'b10, 1'b0, 7'h7C, 32'h0);
    do_req(1'b0, 1'b0, 2'b00, 1'b0, 7'h00, 32'h0);

    do_req(1'b1, 1'b1, 2'b10, 1'b0, 7'h08, 32'h11223344);
    for (int i = 0; i < 4; i++) do_req(1'b1, 1'b0, 2'b00, 1'b0, 7'(8 + i), 32'h0);

    do_req(1'b1, 1'b1, 2'b00, 1'b0, 7'h0D, 32'hFFFFFF80);
    do_req(1'b1, 1'b0, 2'b00, 1'b0, 7'h0D, 32'h0);
    do_req(1'b1, 1'b0, 2'b00, 1'b1, 7'h0D, 32'h0);
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 7'h0C, 32'h0);

    do_req(1'b1, 1'b1, 2'b01, 1'b0, 7'h12, 32'h1234BEEF);
    do_req(1'b1, 1'b0, 2'b01, 1'b0, 7'h12, 32'h0);
    do_req(1'b1, 1'b0, 2'b01, 1'b1, 7'h12, 32'h0);
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 7'h10, 32'h0);

    do_req(1'b1, 1'b1, 2'b10, 1'b0, 7'h05, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 2'b01, 1'b0, 7'h03, 32'h0);
    do_req(1'b1, 1'b1, 2'b11, 1'b0, 7'h04, 32'hA5A5A5A5);
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 7'h04, 32'h0);
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 7'h00, 32'h0);
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 7'h08, 32'h0);

    // Top-of-memory boundary
    do_req(1'b1, 1'b1, 2'b10, 1'b0, 7'h7C, 32'h89ABCDEF);
    do_req(1'b1, 1'b0, 2'b00, 1'b0, 7'h7F, 32'h0);
    do_req(1'b1, 1'b0, 2'b01, 1'b1, 7'h7E, 32'h0);

    for (int n = 0; n < 400; n++) begin
      v    = ($urandom_range(0, 3) != 0);
      we   = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      addr = ADDR_W'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 4) != 0 && size != 2'b11) begin
        mask = ADDR_W'((1 << size) - 1);
        addr = addr & ~mask;
      end
      do_req(v, we, size, uns, addr, $urandom);
    end

    // Reset arriving together with a load: the response is dropped
    do_req(1'b1, 1'b1, 2'b10, 1'b0, 7'h08, 32'hCAFEF00D);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'b10;
    req_addr  = 7'h08;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rst_drop_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_drop_init_done", 32'(init_done), 32'd0);
    chk("rst_drop_req_ready", 32'(req_ready), 32'd0);

    // Reset in the middle of INIT restarts the full clear
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_init_done", 32'(init_done), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_init(cyc, stray);
    chk("reinit_cycles", 32'(cyc), 32'd32);
    chk("reinit_stray_rsp", 32'(stray), 32'd0);
    model_clear();

    do_req(1'b1, 1'b0, 2'b10, 1'b0, 7'h08, 32'h0);
    do_req(1'b1, 1'b0, 2'b10, 1'b0, 7'h7C, 32'h0);
    do_req(1'b1, 1'b0, 2'b00, 1'b0, 7'h0D, 32'h0);
    do_req(1'b0, 1'b0, 2'b00, 1'b0, 7'h00, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
